// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM states,
// stall masks (bit0 PC .. bit5 WB, 1 = Stop) and exception codes.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH      = 2'd2
    } ctrl_state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INV     = 32'h0000_000A;
    localparam logic [31:0] EXC_OV      = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

endpackage

// File: rtl/exc_target_sel.sv
// Combinational redirect-target selection for an exception code.
module exc_target_sel
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic [31:0] excepttype_i,
    input  logic [31:0] epc_i,
    output logic [31:0] target_o
);

    always_comb begin
        target_o = EXC_VECTOR;
        unique case (excepttype_i)
            EXC_INT:  target_o = INT_VECTOR;
            EXC_ERET: target_o = epc_i;
            default:  target_o = EXC_VECTOR;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge plus exception/ERET flush sequencing.
// Optional perf counters enabled by macro PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    ctrl_state_t state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] sel_code, sel_epc, target;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic        bus_busy;

    assign bus_busy = stallreq_from_if | stallreq_from_mem;

    // In RUN the live inputs pick the target so ERET uses this cycle's EPC;
    // while waiting, the latched pair does.
    assign sel_code = (state_q == RUN) ? excepttype_i : code_q;
    assign sel_epc  = (state_q == RUN) ? cp0_epc_i    : epc_q;

    exc_target_sel #(
        .INT_VECTOR(INT_VECTOR),
        .EXC_VECTOR(EXC_VECTOR)
    ) u_sel (
        .excepttype_i(sel_code),
        .epc_i       (sel_epc),
        .target_o    (target)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        epc_d   = epc_q;
        stall   = STALL_NONE;
        unique case (state_q)
            RUN: begin
                if (excepttype_i != 32'h0) begin
                    stall   = STALL_ALL;
                    code_d  = excepttype_i;
                    epc_d   = cp0_epc_i;
                    state_d = bus_busy ? FLUSH_WAIT : FLUSH;
                end else if (stallreq_from_mem) stall = STALL_MEM;
                else if (stallreq_from_ex)      stall = STALL_EX;
                else if (stallreq_from_id)      stall = STALL_ID;
                else if (stallreq_from_if)      stall = STALL_IF;
            end
            FLUSH_WAIT: begin
                stall = STALL_ALL;
                if (!bus_busy) state_d = FLUSH;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
        if (rst) stall = STALL_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            code_q   <= 32'h0;
            epc_q    <= 32'h0;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            flush_q <= (state_d == FLUSH);
            if (state_d == FLUSH) new_pc_q <= target;
        end
    end

    assign flush  = flush_q;
    assign new_pc = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'h0;
            flush_count_q  <= 32'h0;
        end else begin
            if (stall[0] && stall_cycles_q != 32'hFFFF_FFFF)
                stall_cycles_q <= stall_cycles_q + 32'h1;
            if (state_q == FLUSH && flush_count_q != 32'hFFFF_FFFF)
                flush_count_q <= flush_count_q + 32'h1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = 32'h0;
    assign flush_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, flush timing, ERET EPC
// capture, bus-deferred flush, reset abort and perf counters.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_if, sr_id, sr_ex, sr_mem;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc, stall_cycles, flush_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_if (sr_if),
        .stallreq_from_id (sr_id),
        .stallreq_from_ex (sr_ex),
        .stallreq_from_mem(sr_mem),
        .excepttype_i     (exc),
        .cp0_epc_i        (epc),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .stall_cycles_o   (stall_cycles),
        .flush_count_o    (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs are then driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic i_f, input logic i_d, input logic e_x,
                         input logic m_m, input logic [31:0] code);
        sr_if = i_f; sr_id = i_d; sr_ex = e_x; sr_mem = m_m; exc = code;
    endtask

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        rst = 1'b1; epc = 32'h0;
        drive(0, 0, 0, 1, 32'h0);
        tick(); tick(); settle();
        chk("rst_stall", {26'h0, stall}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        chk("rst_scnt", stall_cycles, 32'h0);

        // Stall priority, excepttype zero
        tick(); rst = 1'b0; drive(0, 0, 1, 0, 32'h0); settle();
        chk("ex_stall", {26'h0, stall}, 32'h0000_000F);
        chk("ex_flush", {31'h0, flush}, 32'h0);
        tick(); drive(0, 0, 1, 1, 32'h0); settle();
        chk("mem_stall", {26'h0, stall}, 32'h0000_001F);
        tick(); drive(1, 1, 0, 0, 32'h0); settle();
        chk("id_stall", {26'h0, stall}, 32'h0000_0007);
        tick(); drive(1, 0, 0, 0, 32'h0); settle();
        chk("if_stall", {26'h0, stall}, 32'h0000_0007);
        tick(); drive(0, 0, 0, 0, 32'h0); settle();
        chk("no_stall", {26'h0, stall}, 32'h0);

        // Syscall, no bus busy: flush next cycle to EXC_VECTOR
        tick(); drive(0, 0, 0, 0, 32'h8); settle();
        chk("sys_n_stall", {26'h0, stall}, 32'h0000_003F);
        chk("sys_n_flush", {31'h0, flush}, 32'h0);
        tick(); drive(0, 0, 0, 0, 32'h0); settle();
        chk("sys_n1_flush", {31'h0, flush}, 32'h1);
        chk("sys_n1_newpc", new_pc, 32'h0000_0040);
        chk("sys_n1_stall", {26'h0, stall}, 32'h0);

        // Back-to-back: ERET accepted right after FLUSH, EPC sampled now
        tick(); drive(0, 0, 0, 0, 32'hE); epc = 32'hBFC0_0100; settle();
        chk("sys_n2_flush", {31'h0, flush}, 32'h0);
        chk("sys_n2_newpc", new_pc, 32'h0000_0040);
        chk("eret_stall", {26'h0, stall}, 32'h0000_003F);
        // FLUSH cycle ignores both stall requests and a new exception
        tick(); drive(0, 0, 0, 1, 32'h8); epc = 32'h0; settle();
        chk("eret_flush", {31'h0, flush}, 32'h1);
        chk("eret_newpc", new_pc, 32'hBFC0_0100);
        chk("eret_fl_stall", {26'h0, stall}, 32'h0);
        tick(); drive(0, 0, 0, 0, 32'h0); settle();
        chk("ign_flush", {31'h0, flush}, 32'h0);
        tick(); settle();
        chk("ign_flush2", {31'h0, flush}, 32'h0);
        chk("ign_newpc", new_pc, 32'hBFC0_0100);

        // Interrupt with MEM busy 3 cycles: 4 frozen cycles then flush
        tick(); drive(0, 0, 0, 1, 32'h1); settle();
        chk("int_c0", {26'h0, stall}, 32'h0000_003F);
        for (int k = 1; k < 4; k++) begin
            tick(); drive(0, 0, 0, (k < 3), 32'h0); settle();
            chk($sformatf("int_c%0d_stall", k), {26'h0, stall}, 32'h0000_003F);
            chk($sformatf("int_c%0d_flush", k), {31'h0, flush}, 32'h0);
        end
        tick(); settle();
        chk("int_flush", {31'h0, flush}, 32'h1);
        chk("int_newpc", new_pc, 32'h0000_0020);
        // 4 + 1 + 1 + 4 frozen-PC cycles so far
        tick(); settle();
        chk("scnt_mid", stall_cycles, perf(32'd10));
        chk("fcnt_mid", flush_count, perf(32'd3));

        // Reset during FLUSH_WAIT discards the pending flush
        drive(0, 0, 0, 1, 32'hC); settle();
        tick(); drive(0, 0, 0, 1, 32'h0); rst = 1'b1; settle();
        chk("rstw_stall", {26'h0, stall}, 32'h0);
        tick(); rst = 1'b0; drive(0, 0, 0, 0, 32'h0); settle();
        chk("rstw_flush", {31'h0, flush}, 32'h0);
        chk("rstw_newpc", new_pc, 32'h0);
        chk("rstw_scnt", stall_cycles, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk($sformatf("rstw_noflush%0d", k), {31'h0, flush}, 32'h0);
        end

        // 10 stalled cycles + 2 exceptions without bus wait
        for (int k = 0; k < 10; k++) begin
            tick(); drive(0, 0, 1, 0, 32'h0); settle();
        end
        tick(); drive(0, 0, 0, 0, 32'hA); settle();
        tick(); drive(0, 0, 0, 0, 32'h0); settle();
        chk("inv_newpc", new_pc, 32'h0000_0040);
        tick(); drive(0, 0, 0, 0, 32'hD); settle();
        tick(); drive(0, 0, 0, 0, 32'h0); settle();
        chk("trap_flush", {31'h0, flush}, 32'h1);
        tick(); settle();
        chk("perf_scnt", stall_cycles, perf(32'd12));
        chk("perf_fcnt", flush_count, perf(32'd2));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
